// File: rtl/ssp_slave_frame.sv
// ssp_slave_frame: SPI mode-0 slave front end for the SSP_UART register port.
// Oversamples SSEL_n/SCK/MOSI in the system clock domain, decodes each 16-bit
// frame {RA[2:0], WnR, D[11:0]} into UART strobes and shifts SSP_DO out on MISO.
module ssp_slave_frame #(
    parameter int   SYNC_STAGES = 2,
    parameter logic MISO_IDLE   = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ssel_n,
    input  logic        i_sck,
    input  logic        i_mosi,
    output logic        o_miso,
    output logic        o_miso_oe,
    output logic        o_ssp_ssel,
    output logic        o_ssp_sck,
    output logic [2:0]  o_ssp_ra,
    output logic        o_ssp_wnr,
    output logic        o_ssp_en,
    output logic        o_ssp_eoc,
    output logic [11:0] o_ssp_di,
    input  logic [11:0] i_ssp_do,
    output logic        o_frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] r_sselSync;
    logic [SYNC_STAGES-1:0] r_armSync;
    logic [SYNC_STAGES-1:0] r_sckSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic                   r_sckDly;
    logic                   r_armed;

    state_t      r_state;
    logic [4:0]  r_bitCnt;
    logic [10:0] r_shiftIn;
    logic [11:0] r_misoData;
    logic        r_loadDo;
    logic        r_errSeen;
    logic        r_miso;
    logic        r_misoOe;
    logic [2:0]  r_ra;
    logic        r_wnr;
    logic        r_en;
    logic        r_eoc;
    logic [11:0] r_di;
    logic        r_frameErr;

    logic        w_sselAct;
    logic        w_sckRise;
    logic        w_sckFall;
    logic        w_mosi;
    logic [11:0] w_shiftNext;
    logic [15:0] w_misoWord;
    logic [3:0]  w_misoIdx;
    logic        w_misoBit;

    // Pin synchronizers, the SCK delay flop for edge detection, and the arming
    // chain. The arming chain resets to "selected" so a select held low through
    // reset release never starts a frame; only a deselect followed by a fresh
    // select does.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sselSync <= '1;
            r_armSync  <= '0;
            r_sckSync  <= '0;
            r_mosiSync <= '0;
            r_sckDly   <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_sselSync <= {r_sselSync[SYNC_STAGES-2:0], i_ssel_n};
            r_armSync  <= {r_armSync[SYNC_STAGES-2:0], i_ssel_n};
            r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], i_sck};
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], i_mosi};
            r_sckDly   <= r_sckSync[SYNC_STAGES-1];
            if (r_armSync[SYNC_STAGES-1]) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_sselAct   = ~r_sselSync[SYNC_STAGES-1];
    assign w_sckRise   = r_sckSync[SYNC_STAGES-1] & ~r_sckDly;
    assign w_sckFall   = ~r_sckSync[SYNC_STAGES-1] & r_sckDly;
    assign w_mosi      = r_mosiSync[SYNC_STAGES-1];
    assign w_shiftNext = {r_shiftIn, w_mosi};

    // The falling edge after rising edge k presents frame bit 15-k; the four
    // header slots always return zero.
    assign w_misoWord = {4'b0000, r_misoData};
    assign w_misoIdx  = 4'd15 - r_bitCnt[3:0];
    assign w_misoBit  = w_misoWord[w_misoIdx];

    // Frame FSM: header/data decode, UART strobes, MISO shifting and error pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_bitCnt   <= '0;
            r_shiftIn  <= '0;
            r_misoData <= '0;
            r_loadDo   <= 1'b0;
            r_errSeen  <= 1'b0;
            r_miso     <= MISO_IDLE;
            r_misoOe   <= 1'b0;
            r_ra       <= '0;
            r_wnr      <= 1'b0;
            r_en       <= 1'b0;
            r_eoc      <= 1'b0;
            r_di       <= '0;
            r_frameErr <= 1'b0;
        end else begin
            r_en       <= 1'b0;
            r_eoc      <= 1'b0;
            r_frameErr <= 1'b0;
            r_loadDo   <= r_en;
            case (r_state)
                ST_IDLE: begin
                    r_miso   <= MISO_IDLE;
                    r_misoOe <= 1'b0;
                    if (w_sselAct && r_armed) begin
                        r_state    <= ST_HDR;
                        r_bitCnt   <= '0;
                        r_shiftIn  <= '0;
                        r_misoData <= '0;
                        r_errSeen  <= 1'b0;
                        r_miso     <= 1'b0;
                        r_misoOe   <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (!w_sselAct) begin
                        r_frameErr <= 1'b1;
                        r_state    <= ST_IDLE;
                        r_miso     <= MISO_IDLE;
                        r_misoOe   <= 1'b0;
                    end else if (w_sckRise) begin
                        r_shiftIn <= w_shiftNext[10:0];
                        r_bitCnt  <= r_bitCnt + 5'd1;
                        if (r_bitCnt == 5'd3) begin
                            r_ra    <= w_shiftNext[3:1];
                            r_wnr   <= w_shiftNext[0];
                            r_en    <= 1'b1;
                            r_state <= ST_DATA;
                        end
                    end else if (w_sckFall) begin
                        r_miso <= w_misoBit;
                    end
                end
                ST_DATA: begin
                    // A 16th edge arriving together with deselect still completes the frame.
                    if (w_sckRise && r_bitCnt == 5'd15) begin
                        r_bitCnt <= 5'd16;
                        r_eoc    <= 1'b1;
                        // SSP_DI carries write data, so read frames leave it untouched.
                        if (r_wnr) begin
                            r_di <= w_shiftNext;
                        end
                        if (w_sselAct) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_miso   <= MISO_IDLE;
                            r_misoOe <= 1'b0;
                        end
                    end else if (!w_sselAct) begin
                        r_frameErr <= 1'b1;
                        r_state    <= ST_IDLE;
                        r_miso     <= MISO_IDLE;
                        r_misoOe   <= 1'b0;
                    end else if (w_sckRise) begin
                        r_shiftIn <= w_shiftNext[10:0];
                        r_bitCnt  <= r_bitCnt + 5'd1;
                    end else if (w_sckFall) begin
                        r_miso <= w_misoBit;
                    end
                    if (r_loadDo) begin
                        r_misoData <= i_ssp_do;
                    end
                end
                ST_DONE: begin
                    if (w_sckRise && !r_errSeen) begin
                        r_frameErr <= 1'b1;
                        r_errSeen  <= 1'b1;
                    end
                    if (!w_sselAct) begin
                        r_state  <= ST_IDLE;
                        r_miso   <= MISO_IDLE;
                        r_misoOe <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_miso      = r_miso;
    assign o_miso_oe   = r_misoOe;
    assign o_ssp_ssel  = w_sselAct;
    assign o_ssp_sck   = r_sckSync[SYNC_STAGES-1];
    assign o_ssp_ra    = r_ra;
    assign o_ssp_wnr   = r_wnr;
    assign o_ssp_en    = r_en;
    assign o_ssp_eoc   = r_eoc;
    assign o_ssp_di    = r_di;
    assign o_frame_err = r_frameErr;

endmodule

// File: tb/tb_ssp_slave_frame.sv
// tb_ssp_slave_frame: directed frames against ssp_slave_frame with hand-computed
// expectations for decode, MISO readback, aborts, over-length and reset.
module tb_ssp_slave_frame;

    logic        clock = 1'b0;
    logic        resetN;
    logic        sselN;
    logic        sck;
    logic        mosi;
    logic [11:0] sspDo;

    logic        miso;
    logic        misoOe;
    logic        sspSsel;
    logic        sspSck;
    logic [2:0]  sspRa;
    logic        sspWnr;
    logic        sspEn;
    logic        sspEoc;
    logic [11:0] sspDi;
    logic        frameErr;

    int vectors     = 0;
    int miscompares = 0;
    int enCount     = 0;
    int eocCount    = 0;
    int errCount    = 0;

    logic [2:0]  raLog[$];
    logic [11:0] diLog[$];
    logic [15:0] misoCapture;

    ssp_slave_frame #(
        .SYNC_STAGES(2),
        .MISO_IDLE  (1'b1)
    ) dut (
        .i_clk      (clock),
        .i_rst_n    (resetN),
        .i_ssel_n   (sselN),
        .i_sck      (sck),
        .i_mosi     (mosi),
        .o_miso     (miso),
        .o_miso_oe  (misoOe),
        .o_ssp_ssel (sspSsel),
        .o_ssp_sck  (sspSck),
        .o_ssp_ra   (sspRa),
        .o_ssp_wnr  (sspWnr),
        .o_ssp_en   (sspEn),
        .o_ssp_eoc  (sspEoc),
        .o_ssp_di   (sspDi),
        .i_ssp_do   (sspDo),
        .o_frame_err(frameErr)
    );

    // Free-running system clock.
    always #5 clock = ~clock;

    // Pulse monitor: counts strobes and logs RA at each SSP_En and DI at each SSP_EOC.
    always @(negedge clock) begin
        if (sspEn) begin
            enCount++;
            raLog.push_back(sspRa);
        end
        if (sspEoc) begin
            eocCount++;
            diLog.push_back(sspDi);
        end
        if (frameErr) begin
            errCount++;
        end
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One SCK period at Clk/16; MISO is sampled just before the rising edge.
    task automatic sendBit(input logic b, input int idx);
        mosi = b;
        waitClocks(8);
        if (idx < 16) begin
            misoCapture[15-idx] = miso;
        end
        sck = 1'b1;
        waitClocks(8);
        sck = 1'b0;
    endtask

    // Runs one frame of nBits (bits past 16 are ones); edgeEnd raises SSEL_n
    // together with the last rising SCK edge.
    task automatic applyStimulus(input logic [15:0] word, input int nBits,
                                 input logic [11:0] doVal, input bit edgeEnd,
                                 input int gap);
        sspDo       = doVal;
        misoCapture = '0;
        sselN       = 1'b0;
        for (int i = 0; i < nBits; i++) begin
            logic b;
            b = (i < 16) ? word[15-i] : 1'b1;
            if (edgeEnd && i == nBits - 1) begin
                mosi = b;
                waitClocks(8);
                misoCapture[15-i] = miso;
                sck   = 1'b1;
                sselN = 1'b1;
                waitClocks(8);
                sck = 1'b0;
            end else begin
                sendBit(b, i);
            end
        end
        if (!edgeEnd) begin
            waitClocks(8);
            sselN = 1'b1;
        end
        waitClocks(gap);
    endtask

    initial begin
        int e0;
        int c0;
        int f0;
        int n0;
        int d0;
        logic [15:0] resetWord;

        resetN = 1'b0;
        sselN  = 1'b1;
        sck    = 1'b0;
        mosi   = 1'b0;
        sspDo  = '0;

        // Reset state: MISO idles high, everything else low.
        waitClocks(3);
        checkOutput("reset_outputs",
                    {misoOe, miso, sspSsel, sspSck, sspRa, sspWnr, sspEn, sspEoc, frameErr},
                    {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        checkOutput("reset_di", sspDi, 12'h000);
        resetN = 1'b1;
        waitClocks(10);

        // Write frame 16'h3A5C -> RA=1, WnR=1, DI=A5C; MISO returns {4'b0, DO}.
        e0 = enCount; c0 = eocCount; f0 = errCount;
        applyStimulus(16'h3A5C, 16, 12'h123, 1'b0, 12);
        checkOutput("wr_ra", sspRa, 3'd1);
        checkOutput("wr_wnr", sspWnr, 1'b1);
        checkOutput("wr_en_count", enCount - e0, 1);
        checkOutput("wr_eoc_count", eocCount - c0, 1);
        checkOutput("wr_err_count", errCount - f0, 0);
        checkOutput("wr_di", sspDi, 12'hA5C);
        checkOutput("wr_miso", misoCapture, 16'h0123);
        checkOutput("idle_miso", {misoOe, miso}, 2'b01);

        // Read frame 16'h4000 -> RA=2, WnR=0; MISO = 09C3; DI keeps write data.
        c0 = eocCount;
        applyStimulus(16'h4000, 16, 12'h9C3, 1'b0, 12);
        checkOutput("rd_ra", sspRa, 3'd2);
        checkOutput("rd_wnr", sspWnr, 1'b0);
        checkOutput("rd_miso", misoCapture, 16'h09C3);
        checkOutput("rd_di", sspDi, 12'hA5C);
        checkOutput("rd_eoc_count", eocCount - c0, 1);

        // Deselect in the same Clk as the 16th edge: the edge wins.
        c0 = eocCount; f0 = errCount;
        applyStimulus(16'h1234, 16, 12'h000, 1'b1, 12);
        checkOutput("edge_eoc_count", eocCount - c0, 1);
        checkOutput("edge_err_count", errCount - f0, 0);
        checkOutput("edge_di", sspDi, 12'h234);
        checkOutput("edge_ra", sspRa, 3'd0);

        // Abort after 9 bits: En once, no EOC, one error, DI held.
        e0 = enCount; c0 = eocCount; f0 = errCount;
        applyStimulus(16'h7123, 9, 12'h000, 1'b0, 12);
        checkOutput("abort_en_count", enCount - e0, 1);
        checkOutput("abort_eoc_count", eocCount - c0, 0);
        checkOutput("abort_err_count", errCount - f0, 1);
        checkOutput("abort_di", sspDi, 12'h234);
        checkOutput("abort_ra", sspRa, 3'd3);

        // Over-length: 18 edges of ones -> one EOC, DI=FFF, exactly one error.
        e0 = enCount; c0 = eocCount; f0 = errCount;
        applyStimulus(16'hFFFF, 18, 12'h000, 1'b0, 12);
        checkOutput("over_en_count", enCount - e0, 1);
        checkOutput("over_eoc_count", eocCount - c0, 1);
        checkOutput("over_err_count", errCount - f0, 1);
        checkOutput("over_di", sspDi, 12'hFFF);
        checkOutput("over_ra", sspRa, 3'd7);

        // Reset asserted during bit 10 of a frame.
        resetWord = 16'h2ABC;
        sselN = 1'b0;
        for (int i = 0; i < 9; i++) begin
            sendBit(resetWord[15-i], i);
        end
        mosi = resetWord[6];
        waitClocks(8);
        sck = 1'b1;
        waitClocks(2);
        #2 resetN = 1'b0;
        #1;
        checkOutput("midreset_outputs",
                    {misoOe, miso, sspSsel, sspSck, sspRa, sspWnr, sspEn, sspEoc, frameErr},
                    {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        checkOutput("midreset_di", sspDi, 12'h000);
        waitClocks(6);
        sck = 1'b0;
        waitClocks(4);

        // Release with SSEL_n still low: no frame may start.
        resetN = 1'b1;
        waitClocks(10);
        e0 = enCount;
        for (int i = 0; i < 4; i++) begin
            sendBit(1'b0, 16);
        end
        waitClocks(8);
        checkOutput("noarm_en_count", enCount - e0, 0);
        checkOutput("noarm_oe", misoOe, 1'b0);
        sselN = 1'b1;
        waitClocks(12);

        // Fresh frame after reset: 16'h5123 -> RA=2, WnR=1, DI=123.
        c0 = eocCount; f0 = errCount;
        applyStimulus(16'h5123, 16, 12'h000, 1'b0, 12);
        checkOutput("postreset_ra", sspRa, 3'd2);
        checkOutput("postreset_wnr", sspWnr, 1'b1);
        checkOutput("postreset_di", sspDi, 12'h123);
        checkOutput("postreset_eoc_count", eocCount - c0, 1);
        checkOutput("postreset_err_count", errCount - f0, 0);

        // Back-to-back frames with a 4-Clk deselect gap.
        n0 = raLog.size();
        d0 = diLog.size();
        f0 = errCount;
        applyStimulus(16'hB456, 16, 12'h000, 1'b0, 4);
        applyStimulus(16'hD789, 16, 12'h000, 1'b0, 12);
        checkOutput("b2b_en_count", raLog.size() - n0, 2);
        checkOutput("b2b_eoc_count", diLog.size() - d0, 2);
        checkOutput("b2b_ra0", (raLog.size() > n0) ? raLog[n0] : 3'bxxx, 3'd5);
        checkOutput("b2b_ra1", (raLog.size() > n0 + 1) ? raLog[n0+1] : 3'bxxx, 3'd6);
        checkOutput("b2b_di0", (diLog.size() > d0) ? diLog[d0] : 12'hxxx, 12'h456);
        checkOutput("b2b_di1", (diLog.size() > d0 + 1) ? diLog[d0+1] : 12'hxxx, 12'h789);
        checkOutput("b2b_err_count", errCount - f0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
